// File: rtl/alu_pkg.sv
// Shared opcode set and controller state encoding for the ALU and its controller.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_AND = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU driven by alu_ctrl; results wrap modulo 2^DATA_WIDTH.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [2:0]            oc,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] f
);

  // Divide by zero returns all ones; the controller flags and discards it.
  always_comb begin
    f = '0;
    case (oc)
      OP_ADD:  f = a + b;
      OP_SUB:  f = a - b;
      OP_MUL:  f = a * b;
      OP_DIV:  f = (b == '0) ? '1 : a / b;
      OP_NOT:  f = ~a;
      OP_XOR:  f = a ^ b;
      OP_OR:   f = a | b;
      OP_AND:  f = a & b;
      default: f = '0;
    endcase
  end

endmodule

// File: rtl/alu_regfile.sv
// Register file: two operand read ports plus an observation port, one write
// path where the writeback source overrides an external load to the same entry.
module alu_regfile #(
  parameter  int DATA_WIDTH = 16,
  parameter  int REG_COUNT  = 8,
  localparam int AW         = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         ra1,
  output logic [DATA_WIDTH-1:0] rd1,
  input  logic [AW-1:0]         ra2,
  output logic [DATA_WIDTH-1:0] rd2,
  input  logic [AW-1:0]         ra3,
  output logic [DATA_WIDTH-1:0] rd3,
  input  logic                  wb_en,
  input  logic [AW-1:0]         wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  ld_en,
  input  logic [AW-1:0]         ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
);

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];

  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];
  assign rd3 = regs_q[ra3];

  // Writeback is applied last so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (ld_en) regs_d[ld_addr] = ld_data;
    if (wb_en) regs_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// ALU initiator: accepts 3-operand commands, drives registered ALU operands,
// captures the result and writes it back (IDLE -> EXEC -> WB).
module alu_ctrl
  import alu_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int REG_COUNT  = 8,
  localparam int AW         = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_oc,
  input  logic [AW-1:0]         cmd_dst,
  input  logic [AW-1:0]         cmd_src1,
  input  logic [AW-1:0]         cmd_src2,
  input  logic                  ld_en,
  input  logic [AW-1:0]         ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [2:0]            alu_oc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [AW-1:0]         res_dst,
  output logic                  res_err
);

  state_e                state_q,    state_d;
  logic [2:0]            alu_oc_q,   alu_oc_d;
  logic [DATA_WIDTH-1:0] alu_a_q,    alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q,    alu_b_d;
  logic [AW-1:0]         dst_q,      dst_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [AW-1:0]         res_dst_q,  res_dst_d;
  logic                  res_err_q,  res_err_d;

  logic [DATA_WIDTH-1:0] src1_val;
  logic [DATA_WIDTH-1:0] src2_val;
  logic                  wb_en;

  assign wb_en = (state_q == ST_WB) && !res_err_q;

  alu_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra1     (cmd_src1),
    .rd1     (src1_val),
    .ra2     (cmd_src2),
    .rd2     (src2_val),
    .ra3     (rd_addr),
    .rd3     (rd_data),
    .wb_en   (wb_en),
    .wb_addr (dst_q),
    .wb_data (res_data_q),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    alu_oc_d   = alu_oc_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    dst_d      = dst_q;
    res_data_d = res_data_q;
    res_dst_d  = res_dst_q;
    res_err_d  = res_err_q;
    cmd_ready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          alu_oc_d  = cmd_oc;
          alu_a_d   = src1_val;
          alu_b_d   = (cmd_oc == OP_NOT) ? '0 : src2_val;
          dst_d     = cmd_dst;
          res_err_d = 1'b0;
          state_d   = ST_EXEC;
        end
      end
      // A divide by zero is reported with a zero result and suppresses writeback.
      ST_EXEC: begin
        if (alu_oc_q == OP_DIV && alu_b_q == '0) begin
          res_err_d  = 1'b1;
          res_data_d = '0;
        end else begin
          res_err_d  = 1'b0;
          res_data_d = alu_f;
        end
        res_dst_d = dst_q;
        state_d   = ST_WB;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      alu_oc_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      dst_q      <= '0;
      res_data_q <= '0;
      res_dst_q  <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_oc_q   <= alu_oc_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      dst_q      <= dst_d;
      res_data_q <= res_data_d;
      res_dst_q  <= res_dst_d;
      res_err_q  <= res_err_d;
    end
  end

  assign alu_oc    = alu_oc_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_valid = (state_q == ST_WB);
  assign res_data  = res_data_q;
  assign res_dst   = res_dst_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl with the ALU attached; results are checked by a
// scoreboard monitor against hand-computed expectations.
module tb_alu_ctrl;
  import alu_pkg::*;

  localparam int DW = 16;
  localparam int RC = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_oc = '0;
  logic [AW-1:0] cmd_dst = '0, cmd_src1 = '0, cmd_src2 = '0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic [2:0]    alu_oc;
  logic [DW-1:0] alu_a, alu_b, alu_f;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_dst;
  logic          res_err;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] dst;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_ctrl #(.DATA_WIDTH(DW), .REG_COUNT(RC)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_oc(cmd_oc),
    .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .res_valid(res_valid), .res_data(res_data), .res_dst(res_dst), .res_err(res_err)
  );

  alu #(.DATA_WIDTH(DW)) u_alu (.oc(alu_oc), .a(alu_a), .b(alu_b), .f(alu_f));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Results are consumed whenever the strobe is seen, independent of stimulus.
  always @(negedge clk) begin
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe got res_data 0x%0h expected no strobe", res_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("res_data", 32'(res_data), 32'(e.data));
        checkOutput("res_dst",  32'(res_dst),  32'(e.dst));
        checkOutput("res_err",  32'(res_err),  32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic readReg(input string name, input logic [AW-1:0] a, input logic [DW-1:0] expected);
    rd_addr = a;
    #1;
    checkOutput(name, 32'(rd_data), 32'(expected));
  endtask

  task automatic applyStimulus(
    input logic [2:0] oc, input logic [AW-1:0] dst, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
    input logic [DW-1:0] exp_data, input logic exp_err,
    input logic ex_ld, input logic [AW-1:0] ex_addr, input logic [DW-1:0] ex_data,
    input logic wb_ld, input logic [AW-1:0] wb_addr, input logic [DW-1:0] wb_data);
    exp_q.push_back('{data: exp_data, dst: dst, err: exp_err});
    checkOutput("ready_idle", 32'(cmd_ready), 32'd1);
    cmd_oc = oc; cmd_dst = dst; cmd_src1 = s1; cmd_src2 = s2; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checkOutput("ready_exec", 32'(cmd_ready), 32'd0);
    checkOutput("err_clear",  32'(res_err),   32'd0);
    if (ex_ld) begin ld_en = 1'b1; ld_addr = ex_addr; ld_data = ex_data; end
    tick();
    ld_en = 1'b0;
    checkOutput("ready_wb", 32'(cmd_ready), 32'd0);
    if (wb_ld) begin ld_en = 1'b1; ld_addr = wb_addr; ld_data = wb_data; end
    tick();
    ld_en = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_ready",     32'(cmd_ready), 32'd1);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_data",  32'(res_data),  32'd0);
    checkOutput("rst_res_dst",   32'(res_dst),   32'd0);
    checkOutput("rst_res_err",   32'(res_err),   32'd0);
    checkOutput("rst_alu_oc",    32'(alu_oc),    32'd0);
    checkOutput("rst_alu_a",     32'(alu_a),     32'd0);
    checkOutput("rst_alu_b",     32'(alu_b),     32'd0);
    for (int i = 0; i < RC; i++) readReg("rst_reg", AW'(i), 16'h0000);

    // ADD 7+5 into r3
    load(3'd1, 16'd7);
    load(3'd2, 16'd5);
    applyStimulus(OP_ADD, 3'd3, 3'd1, 3'd2, 16'd12, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    readReg("add_r3", 3'd3, 16'd12);
    checkOutput("res_hold", 32'(res_data), 32'd12);

    // SUB wraps, MUL keeps the low bits
    load(3'd1, 16'd3);
    applyStimulus(OP_SUB, 3'd4, 3'd1, 3'd2, 16'hFFFE, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    readReg("sub_r4", 3'd4, 16'hFFFE);
    load(3'd1, 16'h0100);
    load(3'd2, 16'h0100);
    applyStimulus(OP_MUL, 3'd5, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    readReg("mul_r5", 3'd5, 16'h0000);

    // Divide by zero: error, zero result, destination untouched
    load(3'd6, 16'hAAAA);
    load(3'd1, 16'd100);
    load(3'd2, 16'd0);
    applyStimulus(OP_DIV, 3'd6, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    readReg("div_r6", 3'd6, 16'hAAAA);

    // Load to src during EXEC is ignored; load colliding with WB loses
    load(3'd1, 16'd7);
    load(3'd2, 16'd5);
    applyStimulus(OP_ADD, 3'd3, 3'd1, 3'd2, 16'd12, 1'b0, 1'b1, 3'd1, 16'h2000, 1'b1, 3'd3, 16'h1111);
    readReg("wb_wins_r3", 3'd3, 16'd12);
    readReg("exec_ld_r1", 3'd1, 16'h2000);

    // Back-to-back with cmd_valid held: NOT r1 -> r1, then OR r1|r2 -> r3
    load(3'd1, 16'h00FF);
    load(3'd2, 16'h0F0F);
    exp_q.push_back('{data: 16'hFF00, dst: 3'd1, err: 1'b0});
    exp_q.push_back('{data: 16'hFF0F, dst: 3'd3, err: 1'b0});
    cmd_oc = OP_NOT; cmd_dst = 3'd1; cmd_src1 = 3'd1; cmd_src2 = 3'd2; cmd_valid = 1'b1;
    tick();
    cmd_oc = OP_OR; cmd_dst = 3'd3;
    checkOutput("b2b_ready_exec", 32'(cmd_ready), 32'd0);
    checkOutput("not_alu_a",      32'(alu_a),     32'h00FF);
    checkOutput("not_alu_b",      32'(alu_b),     32'h0000);
    tick();
    checkOutput("b2b_ready_wb", 32'(cmd_ready), 32'd0);
    tick();
    checkOutput("b2b_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    checkOutput("or_alu_oc", 32'(alu_oc), 32'(OP_OR));
    checkOutput("or_alu_a",  32'(alu_a),  32'hFF00);
    checkOutput("or_alu_b",  32'(alu_b),  32'h0F0F);
    tick();
    tick();
    readReg("or_r3", 3'd3, 16'hFF0F);

    // Reset during EXEC aborts the command
    cmd_oc = OP_ADD; cmd_dst = 3'd7; cmd_src1 = 3'd1; cmd_src2 = 3'd2; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_ready",     32'(cmd_ready), 32'd1);
    checkOutput("abort_res_valid", 32'(res_valid), 32'd0);
    checkOutput("abort_res_data",  32'(res_data),  32'd0);
    checkOutput("abort_alu_a",     32'(alu_a),     32'd0);
    for (int i = 0; i < RC; i++) readReg("abort_reg", AW'(i), 16'h0000);
    tick();
    tick();
    tick();

    checkOutput("pending_results", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
